// File: rtl/vendor_pkg.sv
// Shared vending-machine definitions: coin codes, coin values and the
// change-dispenser FSM state encoding.
package vendor_pkg;

  typedef logic [1:0] coin_t;

  localparam coin_t COIN_10  = 2'b00;
  localparam coin_t COIN_20  = 2'b01;
  localparam coin_t COIN_50  = 2'b10;
  localparam coin_t COIN_100 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SELECT,
    ST_EJECT,
    ST_DONE
  } state_e;

  // Coin value in 10-cent units.
  function automatic logic [3:0] coin_value(input coin_t code);
    case (code)
      COIN_10: return 4'd1;
      COIN_20: return 4'd2;
      COIN_50: return 4'd5;
      default: return 4'd10;
    endcase
  endfunction

endpackage

// File: rtl/coin_select.sv
// Combinational greedy picker: largest stocked coin whose value does not
// exceed the amount still owed.
module coin_select #(
  parameter int AMT_W = 8
) (
  input  logic [AMT_W-1:0] remaining,
  input  logic [3:0]       stock_empty,
  output logic [1:0]       code,
  output logic             valid
);
  import vendor_pkg::*;

  // NOTE: every combinational output gets a default before any branch, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    code  = COIN_10;
    valid = 1'b0;
    // Ascending scan: a later (larger) eligible coin overrides a smaller one.
    for (int i = 0; i < 4; i++) begin
      if (!stock_empty[i] && (AMT_W'(coin_value(2'(i))) <= remaining)) begin
        code  = 2'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Coin-return unit: computes change from paid/price and ejects it one coin
// at a time to the hopper, reporting completion or a fault.
module change_dispenser #(
  parameter int AMT_W       = 8,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [AMT_W-1:0] paid,
  input  logic [AMT_W-1:0] price,
  input  logic [3:0]       stock_empty,
  input  logic             hopper_ack,
  output logic [1:0]       coin,
  output logic             eject,
  output logic             busy,
  output logic             done,
  output logic             fault,
  output logic [AMT_W-1:0] remaining
);
  import vendor_pkg::*;

  // The counter only has to reach ACK_TIMEOUT-1: the wait ends on the edge
  // that would make it ACK_TIMEOUT.
  localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  state_e           state_q, state_d;
  coin_t            coin_q, coin_d;
  logic             eject_q, eject_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fault_q, fault_d;
  logic [AMT_W-1:0] remaining_q, remaining_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [AMT_W:0]   diff;
  coin_t            sel_code;
  logic             sel_valid;

  assign diff = {1'b0, paid} - {1'b0, price};

  coin_select #(.AMT_W(AMT_W)) u_coin_select (
    .remaining   (remaining_q),
    .stock_empty (stock_empty),
    .code        (sel_code),
    .valid       (sel_valid)
  );

  always_comb begin
    state_d     = state_q;
    coin_d      = coin_q;
    eject_d     = eject_q;
    done_d      = 1'b0;
    fault_d     = fault_q;
    remaining_d = remaining_q;
    cnt_d       = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          fault_d = 1'b0;
          if (diff[AMT_W]) begin
            fault_d     = 1'b1;
            remaining_d = '0;
          end else begin
            remaining_d = diff[AMT_W-1:0];
            state_d     = ST_SELECT;
          end
        end
      end
      ST_SELECT: begin
        if (remaining_q == '0) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else if (sel_valid) begin
          coin_d  = sel_code;
          eject_d = 1'b1;
          cnt_d   = '0;
          state_d = ST_EJECT;
        end else begin
          // No stocked coin fits: remaining keeps the unpaid amount.
          fault_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_EJECT: begin
        if (hopper_ack) begin
          remaining_d = remaining_q - AMT_W'(coin_value(coin_q));
          eject_d     = 1'b0;
          state_d     = ST_SELECT;
        end else if (cnt_q == CNT_LAST) begin
          eject_d = 1'b0;
          fault_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      coin_q      <= COIN_10;
      eject_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      remaining_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      coin_q      <= coin_d;
      eject_q     <= eject_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fault_q     <= fault_d;
      remaining_q <= remaining_d;
      cnt_q       <= cnt_d;
    end
  end

  assign coin      = coin_q;
  assign eject     = eject_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign fault     = fault_q;
  assign remaining = remaining_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Randomized and directed bench for change_dispenser against a transaction
// level model of greedy change-giving with a behavioural hopper.
module tb_change_dispenser;

  localparam int AMT_W   = 8;
  localparam int ACK_T   = 4;
  localparam int MAX_CYC = 3000;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [AMT_W-1:0] paid, price;
  logic [3:0]       stock_empty;
  logic             hopper_ack;
  logic [1:0]       coin;
  logic             eject, busy, done, fault;
  logic [AMT_W-1:0] remaining;

  change_dispenser #(.AMT_W(AMT_W), .ACK_TIMEOUT(ACK_T)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .paid        (paid),
    .price       (price),
    .stock_empty (stock_empty),
    .hopper_ack  (hopper_ack),
    .coin        (coin),
    .eject       (eject),
    .busy        (busy),
    .done        (done),
    .fault       (fault),
    .remaining   (remaining)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Reference model: value table, greedy change, hopper answers after k cycles.
  int VAL [4] = '{1, 2, 5, 10};
  int exp_coins[$], exp_rems[$], got_coins[$], got_rems[$];
  bit exp_borrow, exp_fault, exp_timeout;
  int exp_final, exp_done, exp_change;

  task automatic model(input int p, input int pr, input logic [3:0] st, input int k);
    int rem, best;
    exp_coins.delete();
    exp_rems.delete();
    exp_borrow  = (p < pr);
    exp_fault   = exp_borrow;
    exp_timeout = 0;
    exp_done    = 0;
    exp_change  = exp_borrow ? 0 : p - pr;
    rem         = exp_change;
    while (!exp_borrow) begin
      if (rem == 0) begin
        exp_done = 1;
        break;
      end
      best = -1;
      for (int c = 0; c < 4; c++)
        if (!st[c] && VAL[c] <= rem && (best < 0 || VAL[c] > VAL[best])) best = c;
      if (best < 0) begin
        exp_fault = 1;
        break;
      end
      exp_coins.push_back(best);
      exp_rems.push_back(rem);
      if (k > ACK_T) begin
        exp_fault   = 1;
        exp_timeout = 1;
        break;
      end
      rem -= VAL[best];
    end
    exp_final = rem;
  endtask

  task automatic do_txn(input string name, input int p, input int pr,
                        input logic [3:0] st, input int k, input bit xtra);
    int cyc, hi, last_len, first_ej, done_cyc, done_cnt;
    bit prev_ej, finished;
    model(p, pr, st, k);
    got_coins.delete();
    got_rems.delete();
    hi = 0; last_len = 0; first_ej = -1; done_cyc = -1; done_cnt = 0;
    prev_ej = 0; finished = 0;

    @(negedge clk);
    paid = AMT_W'(p); price = AMT_W'(pr); stock_empty = st; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({name, ".busy1"}, busy, exp_borrow ? 0 : 1);
    check({name, ".rem1"}, remaining, exp_change);
    check({name, ".fault1"}, fault, exp_borrow);

    cyc = 1;
    while (!finished) begin
      if (eject) begin
        if (!prev_ej) begin
          got_coins.push_back(coin);
          got_rems.push_back(remaining);
          if (first_ej < 0) first_ej = cyc;
        end
        hi++;
      end else begin
        if (prev_ej) last_len = hi;
        hi = 0;
      end
      hopper_ack = eject && (hi == k);
      prev_ej = eject;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (xtra && cyc == 3) begin
        start = 1'b1; paid = 8'd200; price = 8'd0;
      end else begin
        start = 1'b0;
      end
      if (!busy) begin
        finished = 1;
      end else if (cyc >= MAX_CYC) begin
        check({name, ".cycle_budget"}, 1, 0);
        finished = 1;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    hopper_ack = 1'b0;
    start = 1'b0;

    check({name, ".n_coins"}, got_coins.size(), exp_coins.size());
    for (int i = 0; i < exp_coins.size() && i < got_coins.size(); i++) begin
      check($sformatf("%s.coin%0d", name, i), got_coins[i], exp_coins[i]);
      check($sformatf("%s.rem%0d", name, i), got_rems[i], exp_rems[i]);
    end
    check({name, ".done_cnt"}, done_cnt, exp_done);
    check({name, ".fault"}, fault, exp_fault);
    check({name, ".remaining"}, remaining, exp_final);
    if (exp_coins.size() > 0) check({name, ".first_eject_cyc"}, first_ej, 2);
    if (!exp_borrow && exp_change == 0) check({name, ".done_cyc"}, done_cyc, 2);
    if (exp_timeout) check({name, ".eject_len"}, last_len, ACK_T);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; paid = '0; price = '0;
    stock_empty = 4'b0000; hopper_ack = 1'b0;
    #12;
    check("rst.coin", coin, 0);
    check("rst.eject", eject, 0);
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.fault", fault, 0);
    check("rst.remaining", remaining, 0);
    @(negedge clk);
    reset = 1'b0;

    do_txn("c15_7", 15, 7, 4'b0000, 2, 0);
    do_txn("c5_5", 5, 5, 4'b0000, 2, 0);
    do_txn("c3_5", 3, 5, 4'b0000, 2, 0);
    do_txn("c5_0_no50", 5, 0, 4'b0100, 1, 0);
    do_txn("no_stock", 7, 0, 4'b1111, 1, 0);
    do_txn("timeout", 2, 0, 4'b0000, 10, 0);
    do_txn("after_to", 2, 0, 4'b0000, 1, 0);
    do_txn("ack_at_limit", 12, 0, 4'b0000, ACK_T, 0);

    // Asynchronous reset while a coin is being ejected.
    @(negedge clk);
    paid = 8'd9; price = 8'd0; stock_empty = 4'b0000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 10 && !eject; i++) @(negedge clk);
    check("rst_mid.eject_before", eject, 1);
    #2 reset = 1'b1;
    #1;
    check("rst_mid.eject", eject, 0);
    check("rst_mid.busy", busy, 0);
    check("rst_mid.remaining", remaining, 0);
    @(negedge clk);
    reset = 1'b0;
    do_txn("post_rst", 15, 7, 4'b0000, 1, 1);

    for (int t = 0; t < 40; t++) begin
      int p, pr, k;
      logic [3:0] st;
      p  = $urandom_range(0, 80);
      pr = $urandom_range(0, 70);
      st = 4'($urandom & $urandom);
      k  = $urandom_range(1, ACK_T + 1);
      do_txn($sformatf("rnd%0d", t), p, pr, st, k, ($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
